stopwatch_display: RTL
======================

Name: stopwatch_display

Overview:
- Downstream consumer of stopwatch_top; drives a 4-digit multiplexed, common-anode 7-segment display as MM.SS.
- Snapshots minutes/seconds/status once per scan frame and converts them to BCD with a sequential double-dabble engine.
- Scans one digit per refresh slot; the decimal point between minutes and seconds shows run state.

Parameters:
REFRESH_DIV, 4, clk cycles per digit slot; legal values >= 3 (simulation 4, hardware ~50000).
BLINK_FRAMES, 2, frames per blink half-period while paused; legal values >= 1.

Ports:
clk  input  1  system clock, all logic on rising edge
rst  input  1  asynchronous, active-high reset
minutes  input  8  binary minutes from stopwatch_top
seconds  input  6  binary seconds from stopwatch_top
status  input  2  00 idle, 01 running, 10 paused, 11 treated as 00
an  output  4  digit enables, active-low; an[0] = seconds ones ... an[3] = minutes tens
seg  output  7  segments {g,f,e,d,c,b,a}, active-low
dp  output  1  decimal point, active-low
ovf  output  1  high while the committed frame had minutes > 99
frame_start  output  1  one-cycle pulse on the edge where the scan enters digit 0

Behaviour:
- Reset (asynchronous, no clock needed): an=1111, seg=1111111, dp=1, ovf=0, frame_start=0. Refresh counter=0, digit_idx=3. All BCD, staging and snapshot regs=0. busy=0, blink_phase=0, frame counter=0.
- Refresh counter counts 0..REFRESH_DIV-1, then wraps. tick = (count==REFRESH_DIV-1).
- On a tick edge, digit_idx advances (3 wraps to 0). an, seg and dp are loaded in the same edge for the new digit, so the outputs are registered.
- First tick after reset release is the REFRESH_DIV-th rising edge. It selects digit 0 and asserts frame_start.
- Frame-start edge (digit_idx 3 -> 0) does all of the following in that one edge:
  - Commits the staging BCD and ovf into the display regs.
  - Decodes digit 0 from the newly committed value.
  - Snapshots minutes, seconds and status, and starts the converter (busy=1).
  - Increments the frame counter. At BLINK_FRAMES it wraps to 0 and toggles blink_phase.
- Converter:
  - Minutes clamped to 99 when > 99 (ovf_stage=1, else 0).
  - Seconds zero-extended to 8 bits.
  - Both values run through 8 shift-and-add-3 iterations in parallel, one iteration per cycle.
  - Staging regs are written on the 8th iteration edge; busy clears on that edge.
  - Because 4*REFRESH_DIV >= 12 > 8, conversion always finishes before the next frame start.
- Latency: a value sampled at the frame N start is displayed throughout frame N+1. Input changes mid-frame are invisible until the next snapshot. No tearing within a frame.
- Seconds 60-63 (illegal upstream) are displayed literally; no clamping, no flag.
- Segment codes (gfedcba, active-low): 0=1000000, 1=1111001, 2=0100100, 3=0110000, 4=0011001, 5=0010010, 6=0000010, 7=1111000, 8=0000000, 9=0010000.
- dp is 1 on digits 0, 1 and 3. On digit 2 it depends on the snapshotted status:
  - Idle or running: dp=0.
  - Paused: dp = ~blink_phase, i.e. lit BLINK_FRAMES frames, dark BLINK_FRAMES frames.
- No leading-zero blanking. All four digits are always driven once scanning starts.
- rst mid-scan or mid-conversion: everything returns to reset values immediately. Scanning restarts exactly as after power-up.

Test Plan:
1. Reset, then release with REFRESH_DIV=4 -> an=1111, seg=1111111, dp=1 until the 4th edge. Then an=1110, seg=1000000, frame_start pulses for 1 cycle, and repeats every 16 cycles.
2. Hold minutes=12, seconds=34, status=01 from reset -> from the 2nd frame onward:
   - an=1110 seg=0011001
   - an=1101 seg=0110000
   - an=1011 seg=0100100 dp=0
   - an=0111 seg=1111001
   - dp=1 on all other digits.
3. minutes=150 -> the next committed frame shows minutes digits 9,9 (seg=0010000 on an=1011 and an=0111), ovf=1. Set minutes=5 -> one frame later ovf=0 and the tens digit shows 0.
4. status=10, BLINK_FRAMES=2 -> dp on digit 2 alternates 2 frames lit, 2 frames dark. Then status=01 -> dp steady 0 from the frame after the snapshot.
5. Change seconds 34->35 two cycles after frame_start -> frame N+1 still shows 34; frame N+2 shows 35 (seg=0010010 on an=1110).
6. Assert rst for 3 ns between clock edges during the converter busy window -> an=1111, seg=1111111, dp=1, ovf=0 immediately. After release, the first frame_start occurs on the 4th edge.

Source files
------------

// File: rtl/stopwatch_display.sv
// Multiplexed MM.SS driver for a 4-digit common-anode 7-segment display.
// Inputs are snapshotted at each frame start, converted to BCD by a sequential
// double-dabble engine, and committed to the scanned digits at the next frame start.
module stopwatch_display #(
  parameter int unsigned REFRESH_DIV  = 4,
  parameter int unsigned BLINK_FRAMES = 2
) (
  input  logic       clk,
  input  logic       rst,
  input  logic [7:0] minutes,
  input  logic [5:0] seconds,
  input  logic [1:0] status,
  output logic [3:0] an,
  output logic [6:0] seg,
  output logic       dp,
  output logic       ovf,
  output logic       frame_start
);

  localparam int unsigned CntW = (REFRESH_DIV > 1) ? $clog2(REFRESH_DIV) : 1;
  localparam int unsigned FrmW = (BLINK_FRAMES > 1) ? $clog2(BLINK_FRAMES) : 1;

  localparam logic [1:0] StatusPaused = 2'b10;

  // Active-low gfedcba pattern for one BCD digit; non-decimal codes blank.
  function automatic logic [6:0] seg_decode(input logic [3:0] d);
    logic [6:0] s;
    case (d)
      4'd0:    s = 7'b1000000;
      4'd1:    s = 7'b1111001;
      4'd2:    s = 7'b0100100;
      4'd3:    s = 7'b0110000;
      4'd4:    s = 7'b0011001;
      4'd5:    s = 7'b0010010;
      4'd6:    s = 7'b0000010;
      4'd7:    s = 7'b1111000;
      4'd8:    s = 7'b0000000;
      4'd9:    s = 7'b0010000;
      default: s = 7'b1111111;
    endcase
    return s;
  endfunction

  // One double-dabble iteration on {bcd[7:0], bin[7:0]}: add-3 correction then shift.
  function automatic logic [15:0] dabble_step(input logic [15:0] v);
    logic [15:0] t;
    t = v;
    if (t[11:8] >= 4'd5) t[11:8] = t[11:8] + 4'd3;
    if (t[15:12] >= 4'd5) t[15:12] = t[15:12] + 4'd3;
    return {t[14:0], 1'b0};
  endfunction

  // Scan state
  logic [CntW-1:0] cnt_q, cnt_d;
  logic [1:0]      idx_q, idx_d;
  logic [3:0]      an_q, an_d;
  logic [6:0]      seg_q, seg_d;
  logic            dp_q, dp_d;
  logic            fs_q, fs_d;
  // Converter / snapshot state
  logic [15:0]     min_sh_q, min_sh_d;
  logic [15:0]     sec_sh_q, sec_sh_d;
  logic [2:0]      iter_q, iter_d;
  logic            busy_q, busy_d;
  logic [1:0]      status_snap_q, status_snap_d;
  logic            ovf_stage_q, ovf_stage_d;
  logic [7:0]      min_stage_q, min_stage_d;
  logic [7:0]      sec_stage_q, sec_stage_d;
  // Committed (displayed) frame
  logic [7:0]      min_bcd_q, min_bcd_d;
  logic [7:0]      sec_bcd_q, sec_bcd_d;
  logic            ovf_q, ovf_d;
  logic [1:0]      status_disp_q, status_disp_d;
  // Blink timing
  logic [FrmW-1:0] frame_cnt_q, frame_cnt_d;
  logic            blink_q, blink_d;

  logic            tick;
  logic            frame_edge;
  logic [7:0]      min_clamped;
  logic [15:0]     min_step;
  logic [15:0]     sec_step;
  logic [3:0]      digit;

  assign tick        = (cnt_q == CntW'(REFRESH_DIV - 1));
  assign frame_edge  = tick && (idx_q == 2'd3);
  assign min_clamped = (minutes > 8'd99) ? 8'd99 : minutes;
  assign min_step    = dabble_step(min_sh_q);
  assign sec_step    = dabble_step(sec_sh_q);

  // Refresh counter, frame commit and blink phase
  always_comb begin
    cnt_d         = tick ? '0 : cnt_q + 1'b1;
    idx_d         = tick ? idx_q + 2'd1 : idx_q;
    fs_d          = frame_edge;
    min_bcd_d     = min_bcd_q;
    sec_bcd_d     = sec_bcd_q;
    ovf_d         = ovf_q;
    status_disp_d = status_disp_q;
    frame_cnt_d   = frame_cnt_q;
    blink_d       = blink_q;
    if (frame_edge) begin
      min_bcd_d     = min_stage_q;
      sec_bcd_d     = sec_stage_q;
      ovf_d         = ovf_stage_q;
      status_disp_d = status_snap_q;
      if (frame_cnt_q == FrmW'(BLINK_FRAMES - 1)) begin
        frame_cnt_d = '0;
        blink_d     = ~blink_q;
      end else begin
        frame_cnt_d = frame_cnt_q + 1'b1;
      end
    end
  end

  // Snapshot at frame start, then eight dabble iterations into the staging regs
  always_comb begin
    min_sh_d      = min_sh_q;
    sec_sh_d      = sec_sh_q;
    iter_d        = iter_q;
    busy_d        = busy_q;
    status_snap_d = status_snap_q;
    ovf_stage_d   = ovf_stage_q;
    min_stage_d   = min_stage_q;
    sec_stage_d   = sec_stage_q;
    if (frame_edge) begin
      min_sh_d      = {8'h00, min_clamped};
      sec_sh_d      = {8'h00, 2'b00, seconds};
      iter_d        = 3'd0;
      busy_d        = 1'b1;
      status_snap_d = status;
      ovf_stage_d   = (minutes > 8'd99);
    end else if (busy_q) begin
      min_sh_d = min_step;
      sec_sh_d = sec_step;
      iter_d   = iter_q + 3'd1;
      if (iter_q == 3'd7) begin
        busy_d      = 1'b0;
        min_stage_d = min_step[15:8];
        sec_stage_d = sec_step[15:8];
      end
    end
  end

  // Registered digit outputs, decoded from the value committed in the same edge
  always_comb begin
    an_d  = an_q;
    seg_d = seg_q;
    dp_d  = dp_q;
    case (idx_d)
      2'd0:    digit = sec_bcd_d[3:0];
      2'd1:    digit = sec_bcd_d[7:4];
      2'd2:    digit = min_bcd_d[3:0];
      default: digit = min_bcd_d[7:4];
    endcase
    if (tick) begin
      an_d  = ~(4'b0001 << idx_d);
      seg_d = seg_decode(digit);
      if (idx_d == 2'd2) begin
        dp_d = (status_disp_d == StatusPaused) ? ~blink_q : 1'b0;
      end else begin
        dp_d = 1'b1;
      end
    end
  end

  // State registers
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cnt_q         <= '0;
      idx_q         <= 2'd3;
      an_q          <= 4'b1111;
      seg_q         <= 7'b1111111;
      dp_q          <= 1'b1;
      fs_q          <= 1'b0;
      min_sh_q      <= '0;
      sec_sh_q      <= '0;
      iter_q        <= '0;
      busy_q        <= 1'b0;
      status_snap_q <= '0;
      ovf_stage_q   <= 1'b0;
      min_stage_q   <= '0;
      sec_stage_q   <= '0;
      min_bcd_q     <= '0;
      sec_bcd_q     <= '0;
      ovf_q         <= 1'b0;
      status_disp_q <= '0;
      frame_cnt_q   <= '0;
      blink_q       <= 1'b0;
    end else begin
      cnt_q         <= cnt_d;
      idx_q         <= idx_d;
      an_q          <= an_d;
      seg_q         <= seg_d;
      dp_q          <= dp_d;
      fs_q          <= fs_d;
      min_sh_q      <= min_sh_d;
      sec_sh_q      <= sec_sh_d;
      iter_q        <= iter_d;
      busy_q        <= busy_d;
      status_snap_q <= status_snap_d;
      ovf_stage_q   <= ovf_stage_d;
      min_stage_q   <= min_stage_d;
      sec_stage_q   <= sec_stage_d;
      min_bcd_q     <= min_bcd_d;
      sec_bcd_q     <= sec_bcd_d;
      ovf_q         <= ovf_d;
      status_disp_q <= status_disp_d;
      frame_cnt_q   <= frame_cnt_d;
      blink_q       <= blink_d;
    end
  end

  assign an          = an_q;
  assign seg         = seg_q;
  assign dp          = dp_q;
  assign ovf         = ovf_q;
  assign frame_start = fs_q;

endmodule
